// File: rtl/mems_dac_sequencer.sv
// Command sequencer for the MEMS mirror DAC: power-on init, then one four-word
// differential frame per accepted (x, y) sample, handshaking with the SPI transmitter.
module mems_dac_sequencer #(
  parameter logic [15:0] BIAS           = 16'd32768,
  parameter logic [15:0] MAX_CODE       = 16'd65535,
  parameter int          STARTUP_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic [23:0] spi_data,
  output logic        spi_start,
  input  logic        spi_busy,
  output logic        init_done,
  output logic        frame_done,
  output logic        clipped
);

  localparam logic [2:0] S_STARTUP    = 3'd0;
  localparam logic [2:0] S_INIT_ISSUE = 3'd1;
  localparam logic [2:0] S_LOAD       = 3'd2;
  localparam logic [2:0] S_SEND       = 3'd3;
  localparam logic [2:0] S_WAIT_HI    = 3'd4;
  localparam logic [2:0] S_WAIT_LO    = 3'd5;
  localparam logic [2:0] S_NEXT       = 3'd6;
  localparam logic [2:0] S_IDLE       = 3'd7;

  localparam int             CW       = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(STARTUP_CYCLES - 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          in_frame;
  logic [15:0]   x_q, y_q;
  logic [15:0]   code_a, code_b, code_c, code_d;

  // Returns {saturated, code}; input is 18-bit signed so BIAS +/- 32768 never wraps.
  function automatic logic [16:0] clamp(input logic signed [17:0] v);
    if (v < 18'sd0)
      return {1'b1, 16'h0000};
    else if (v > $signed({2'b00, MAX_CODE}))
      return {1'b1, MAX_CODE};
    else
      return {1'b0, v[15:0]};
  endfunction

  logic signed [17:0] bias_s, x_s, y_s;
  logic [16:0]        ca, cb, cc, cd;
  logic [1:0]         idx_nxt;
  logic [23:0]        next_word;
  logic               last_word;

  always_comb begin
    bias_s = $signed({2'b00, BIAS});
    x_s    = $signed({{2{x_q[15]}}, x_q});
    y_s    = $signed({{2{y_q[15]}}, y_q});
    ca     = clamp(bias_s + x_s);
    cb     = clamp(bias_s - x_s);
    cc     = clamp(bias_s + y_s);
    cd     = clamp(bias_s - y_s);
  end

  always_comb begin
    idx_nxt   = idx + 2'd1;
    last_word = in_frame ? (idx == 2'd3) : (idx == 2'd2);
    next_word = 24'h280001;
    if (in_frame) begin
      case (idx_nxt)
        2'd1:    next_word = {8'h01, code_b};
        2'd2:    next_word = {8'h02, code_c};
        2'd3:    next_word = {8'h13, code_d};
        default: next_word = {8'h00, code_a};
      endcase
    end else begin
      case (idx_nxt)
        2'd1:    next_word = 24'h380001;
        2'd2:    next_word = 24'h20000F;
        default: next_word = 24'h280001;
      endcase
    end
  end

  assign sample_ready = (state == S_IDLE) && init_done;

  // spi_data is only written on the edge that enters SEND, so it stays put
  // through WAIT_HI/WAIT_LO while the transmitter keeps re-sampling it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_STARTUP;
      cnt        <= '0;
      idx        <= 2'd0;
      in_frame   <= 1'b0;
      x_q        <= 16'h0000;
      y_q        <= 16'h0000;
      code_a     <= 16'h0000;
      code_b     <= 16'h0000;
      code_c     <= 16'h0000;
      code_d     <= 16'h0000;
      spi_data   <= 24'h000000;
      spi_start  <= 1'b0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
      clipped    <= 1'b0;
    end else begin
      spi_start  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_STARTUP: begin
          if (cnt != CNT_LAST)
            cnt <= cnt + CW'(1);
          else if (!spi_busy) begin
            idx      <= 2'd0;
            in_frame <= 1'b0;
            state    <= S_INIT_ISSUE;
          end
        end
        S_INIT_ISSUE: begin
          spi_data  <= 24'h280001;
          spi_start <= 1'b1;
          state     <= S_SEND;
        end
        S_IDLE: begin
          if (sample_valid && sample_ready) begin
            x_q   <= x_in;
            y_q   <= y_in;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          code_a    <= ca[15:0];
          code_b    <= cb[15:0];
          code_c    <= cc[15:0];
          code_d    <= cd[15:0];
          clipped   <= ca[16] | cb[16] | cc[16] | cd[16];
          idx       <= 2'd0;
          in_frame  <= 1'b1;
          spi_data  <= {8'h00, ca[15:0]};
          spi_start <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND:    state <= S_WAIT_HI;
        S_WAIT_HI: if (spi_busy) state <= S_WAIT_LO;
        S_WAIT_LO: begin
          if (!spi_busy) begin
            frame_done <= in_frame && (idx == 2'd3);
            state      <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (last_word) begin
            if (!in_frame) init_done <= 1'b1;
            state <= S_IDLE;
          end else begin
            idx       <= idx_nxt;
            spi_data  <= next_word;
            spi_start <= 1'b1;
            state     <= S_SEND;
          end
        end
        default: state <= S_STARTUP;
      endcase
    end
  end

endmodule
